fb_rect_fill: RTL

Hardware rectangle-fill engine and write arbiter sitting directly upstream of the SPI framebuffer driver's write port. It accepts a solid-colour rectangle command from the MCU, clips it to the 160x120 logical framebuffer, and emits one RGB565 pixel write per cycle on WA/WD/WE. It also merges ordinary MCU pixel writes onto the same port, and those writes take priority over the fill.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_write_arbiter.sv | 48 ++++
 rtl/fb_rect_fill.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: geometry, address width, fill FSM states, pixel type.
package fb_pkg;

  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int FB_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    FILL = 2'd2,
    FIN  = 2'd3
  } FILL_STATE_T;

  typedef logic [15:0] rgb565_t;

  // Row start address y*FB_W built from shifts (160 = 128 + 32).
  function automatic logic [FB_ADDR_W-1:0] row_addr(input logic [6:0] y);
    logic [FB_ADDR_W-1:0] y_ext;
    y_ext    = {{(FB_ADDR_W-7){1'b0}}, y};
    row_addr = (y_ext << 7) + (y_ext << 5);
  endfunction

endpackage

// File: rtl/fb_write_arbiter.sv
// Registered 2:1 write-port mux; MCU writes win and stall the fill engine for that cycle.
module fb_write_arbiter
  import fb_pkg::*;
(
  input  logic                 CLK_50MHz,
  input  logic                 RESET,
  input  logic [FB_ADDR_W-1:0] cpu_wa,
  input  rgb565_t              cpu_wd,
  input  logic                 cpu_we,
  input  logic                 fill_req,
  input  logic [FB_ADDR_W-1:0] fill_wa,
  input  rgb565_t              fill_wd,
  output logic                 fill_stall,
  output logic [FB_ADDR_W-1:0] wa,
  output rgb565_t              wd,
  output logic                 we
);

  logic [FB_ADDR_W-1:0] wa_reg;
  rgb565_t              wd_reg;
  logic                 we_reg;

  // The engine only needs to know the port is taken this cycle.
  assign fill_stall = cpu_we;

  // Register the winning write; address/data hold when nobody writes.
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      wa_reg <= '0;
      wd_reg <= '0;
      we_reg <= 1'b0;
    end else begin
      we_reg <= cpu_we | fill_req;
      if (cpu_we) begin
        wa_reg <= cpu_wa;
        wd_reg <= cpu_wd;
      end else if (fill_req) begin
        wa_reg <= fill_wa;
        wd_reg <= fill_wd;
      end
    end
  end

  assign wa = wa_reg;
  assign wd = wd_reg;
  assign we = we_reg;

endmodule

// File: rtl/fb_rect_fill.sv
// Solid rectangle fill engine with clipping, merged with MCU pixel writes.
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic                 CLK_50MHz,
  input  logic                 RESET,
  input  logic [7:0]           X,
  input  logic [6:0]           Y,
  input  logic [7:0]           W,
  input  logic [6:0]           H,
  input  rgb565_t              COLOR,
  input  logic                 START,
  input  logic [FB_ADDR_W-1:0] CPU_WA,
  input  rgb565_t              CPU_WD,
  input  logic                 CPU_WE,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [FB_ADDR_W-1:0] WA,
  output rgb565_t              WD,
  output logic                 WE
);

  FILL_STATE_T          state_reg, state_next;
  logic [7:0]           x_reg, w_reg, x_end_reg, cur_x_reg;
  logic [6:0]           y_reg, h_reg, y_end_reg, cur_y_reg;
  rgb565_t              color_reg;
  logic [FB_ADDR_W-1:0] row_base_reg;
  logic                 empty_reg;

  logic                 fill_stall, fill_req, last_pix, cmd_empty;
  logic [8:0]           x_sum;
  logic [7:0]           y_sum;
  logic [7:0]           x_end_next;
  logic [6:0]           y_end_next;
  logic [FB_ADDR_W-1:0] fill_wa;

  // Clipping arithmetic on the latched command.
  assign cmd_empty  = (x_reg >= 8'(FB_W)) || (y_reg >= 7'(FB_H)) || (w_reg == 8'd0) || (h_reg == 7'd0);
  assign x_sum      = {1'b0, x_reg} + {1'b0, w_reg};
  assign y_sum      = {1'b0, y_reg} + {1'b0, h_reg};
  assign x_end_next = (x_sum > 9'(FB_W)) ? 8'(FB_W - 1) : 8'(x_sum - 9'd1);
  assign y_end_next = (y_sum > 8'(FB_H)) ? 7'(FB_H - 1) : 7'(y_sum - 8'd1);
  assign last_pix   = (cur_x_reg == x_end_reg) && (cur_y_reg == y_end_reg);
  assign fill_wa    = row_base_reg + {{(FB_ADDR_W-8){1'b0}}, cur_x_reg};

  // State register.
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; the empty verdict registered in CLIP retires the command from FILL with no writes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (START) state_next = CLIP;
      CLIP: state_next = FILL;
      FILL: if (empty_reg || (!fill_stall && last_pix)) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status and fill-request outputs decoded from the state.
  always_comb begin
    BUSY     = 1'b0;
    DONE     = 1'b0;
    fill_req = 1'b0;
    case (state_reg)
      CLIP: BUSY = 1'b1;
      FILL: begin
        BUSY     = 1'b1;
        fill_req = !empty_reg;
      end
      FIN:  DONE = 1'b1;
      default: ;
    endcase
  end

  // Command latch, clip setup and raster counters; counters hold while the MCU owns the port.
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      x_reg        <= '0;
      y_reg        <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      color_reg    <= '0;
      x_end_reg    <= '0;
      y_end_reg    <= '0;
      cur_x_reg    <= '0;
      cur_y_reg    <= '0;
      row_base_reg <= '0;
      empty_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (START) begin
          x_reg     <= X;
          y_reg     <= Y;
          w_reg     <= W;
          h_reg     <= H;
          color_reg <= COLOR;
        end
        CLIP: begin
          empty_reg    <= cmd_empty;
          x_end_reg    <= x_end_next;
          y_end_reg    <= y_end_next;
          cur_x_reg    <= x_reg;
          cur_y_reg    <= y_reg;
          row_base_reg <= row_addr(y_reg);
        end
        FILL: if (fill_req && !fill_stall) begin
          if (cur_x_reg == x_end_reg) begin
            cur_x_reg    <= x_reg;
            cur_y_reg    <= cur_y_reg + 7'd1;
            row_base_reg <= row_base_reg + FB_ADDR_W'(FB_W);
          end else begin
            cur_x_reg <= cur_x_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  fb_write_arbiter u_arb (
    .CLK_50MHz  (CLK_50MHz),
    .RESET      (RESET),
    .cpu_wa     (CPU_WA),
    .cpu_wd     (CPU_WD),
    .cpu_we     (CPU_WE),
    .fill_req   (fill_req),
    .fill_wa    (fill_wa),
    .fill_wd    (color_reg),
    .fill_stall (fill_stall),
    .wa         (WA),
    .wd         (WD),
    .we         (WE)
  );

endmodule
